// File: rtl/clkgen_div.sv
// Lock-qualified reset release plus CHANNELS runtime-programmable clock-enable dividers.
// Divisor writes go through a single pending slot and land only on period boundaries.
module clkgen_div #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOCK_WAIT   = 1024,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                LOCKED_IN,
  input  logic                CFG_VALID,
  input  logic [CH_W-1:0]     CFG_CH,
  input  logic [DIV_W-1:0]    CFG_DIV,
  output logic                CFG_READY,
  output logic [CHANNELS-1:0] EN_OUT,
  output logic [CHANNELS-1:0] SQ_OUT,
  output logic                RST_OUT,
  output logic                READY
);

  localparam int unsigned SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       stab_q, stab_d;
  logic                ready_q, rst_out_q;

  logic [DIV_W-1:0]    div_q [CHANNELS];
  logic [DIV_W-1:0]    div_d [CHANNELS];
  logic [DIV_W-1:0]    cnt_q [CHANNELS];
  logic [DIV_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] sq_q, sq_d;
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] apply;

  logic                pend_v_q, pend_v_d;
  logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
  logic [DIV_W-1:0]    pend_div_q, pend_div_d;

  logic                run, run_d;
  logic                accept, in_range;

  // Lock qualification FSM
  always_comb begin
    state_d = state_q;
    stab_d  = '0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (LOCKED_IN) state_d = STABLE;
      end
      STABLE: begin
        if (!LOCKED_IN) begin
          state_d = WAIT_LOCK;
        end else if (stab_q == SW'(LOCK_WAIT - 1)) begin
          state_d = RUN;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      RUN: begin
        if (!LOCKED_IN) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign run   = (state_q == RUN);
  assign run_d = (state_d == RUN);

  // Pending write lands at the target's period boundary in RUN, or immediately otherwise.
  always_comb begin
    en    = '0;
    apply = '0;
    sq_d  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      en[i]    = run && (cnt_q[i] == (div_q[i] - DIV_W'(1)));
      apply[i] = pend_v_q && (pend_ch_q == CH_W'(i)) && (!run || en[i]);
      div_d[i] = apply[i] ? pend_div_q : div_q[i];
      cnt_d[i] = '0;
      if (run && run_d && !en[i]) cnt_d[i] = cnt_q[i] + DIV_W'(1);
      // Square output is registered from next-cycle count so it tracks cnt in the same cycle.
      sq_d[i]  = run_d && (cnt_d[i] < (div_d[i] >> 1));
    end
  end

  always_comb begin
    in_range = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (CFG_CH == CH_W'(i)) in_range = 1'b1;
    end
  end

  assign accept = CFG_VALID && !pend_v_q;

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_ch_d  = pend_ch_q;
    pend_div_d = pend_div_q;
    if (pend_v_q) begin
      if (|apply) pend_v_d = 1'b0;
    end else if (accept && in_range) begin
      pend_v_d   = 1'b1;
      pend_ch_d  = CFG_CH;
      pend_div_d = (CFG_DIV == '0) ? DIV_W'(1) : CFG_DIV;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= WAIT_LOCK;
      stab_q     <= '0;
      ready_q    <= 1'b0;
      rst_out_q  <= 1'b1;
      sq_q       <= '0;
      pend_v_q   <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        div_q[i] <= DIV_W'(DEFAULT_DIV);
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      stab_q     <= stab_d;
      ready_q    <= run_d;
      rst_out_q  <= !run_d;
      sq_q       <= sq_d;
      pend_v_q   <= pend_v_d;
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign CFG_READY = !pend_v_q;
  assign EN_OUT    = en;
  assign SQ_OUT    = sq_q;
  assign RST_OUT   = rst_out_q;
  assign READY     = ready_q;

endmodule

// File: tb/tb_clkgen_div.sv
// Directed bench for clkgen_div: table-driven lock/release sequence plus
// hand-written divisor, glitch-free update and async-reset sequences.
module tb_clkgen_div;

  localparam int unsigned CHANNELS = 5;
  localparam int unsigned DIV_W    = 16;
  localparam int unsigned CH_W     = 3;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                LOCKED_IN;
  logic                CFG_VALID;
  logic [CH_W-1:0]     CFG_CH;
  logic [DIV_W-1:0]    CFG_DIV;
  logic                CFG_READY;
  logic [CHANNELS-1:0] EN_OUT;
  logic [CHANNELS-1:0] SQ_OUT;
  logic                RST_OUT;
  logic                READY;

  int total = 0;
  int bad   = 0;

  clkgen_div #(
    .CHANNELS(CHANNELS),
    .DIV_W(DIV_W),
    .LOCK_WAIT(8),
    .DEFAULT_DIV(2)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .LOCKED_IN(LOCKED_IN),
    .CFG_VALID(CFG_VALID),
    .CFG_CH(CFG_CH),
    .CFG_DIV(CFG_DIV),
    .CFG_READY(CFG_READY),
    .EN_OUT(EN_OUT),
    .SQ_OUT(SQ_OUT),
    .RST_OUT(RST_OUT),
    .READY(READY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1);
  end

  typedef struct {
    logic       lk;
    logic [4:0] en;
    logic [4:0] sq;
    logic       rst;
    logic       rdy;
    logic       cfgr;
  } vec_t;

  vec_t vecs[$];

  function void add_vec(input logic lk, input logic [4:0] en, input logic [4:0] sq,
                        input logic rst, input logic rdy, input logic cfgr);
    vec_t v;
    v.lk = lk; v.en = en; v.sq = sq; v.rst = rst; v.rdy = rdy; v.cfgr = cfgr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".en"},   32'(EN_OUT),    32'h0);
    chk({tag, ".sq"},   32'(SQ_OUT),    32'h0);
    chk({tag, ".rst"},  32'(RST_OUT),   32'h1);
    chk({tag, ".rdy"},  32'(READY),     32'h0);
    chk({tag, ".cfgr"}, 32'(CFG_READY), 32'h1);
  endtask

  // Single config write outside RUN: slot busy for one cycle unless discarded.
  task automatic cfg_write(input int ch, input int dv, input bit discard);
    CFG_VALID = 1'b1;
    CFG_CH    = CH_W'(ch);
    CFG_DIV   = DIV_W'(dv);
    chk($sformatf("cfg%0d.pre", ch), 32'(CFG_READY), 32'h1);
    step();
    CFG_VALID = 1'b0;
    chk($sformatf("cfg%0d.hold", ch), 32'(CFG_READY), discard ? 32'h1 : 32'h0);
    step();
    chk($sformatf("cfg%0d.free", ch), 32'(CFG_READY), 32'h1);
  endtask

  // LOCKED_IN high from the current cycle; release lands exactly 9 cycles later.
  task automatic lock_and_wait(input string tag);
    LOCKED_IN = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("%s.rdy%0d", tag, k), 32'(READY),   (k == 9) ? 32'h1 : 32'h0);
      chk($sformatf("%s.rst%0d", tag, k), 32'(RST_OUT), (k == 9) ? 32'h0 : 32'h1);
    end
  endtask

  logic [14:0] en_pat [CHANNELS];
  logic [14:0] sq_pat [CHANNELS];
  logic [4:0]  exp_en, exp_sq;
  int          k;

  initial begin
    // Reset release at cycle 0, LOCKED_IN at cycle 10, glitch at cycle 30.
    for (int c = 0; c <= 9; c++)   add_vec(1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b1);
    for (int c = 10; c <= 18; c++) add_vec(1'b1, 5'h00, 5'h00, 1'b1, 1'b0, 1'b1);
    add_vec(1'b1, 5'h00, 5'h1f, 1'b0, 1'b1, 1'b1);  // 19 first RUN cycle
    add_vec(1'b1, 5'h1f, 5'h00, 1'b0, 1'b1, 1'b1);  // 20
    add_vec(1'b1, 5'h00, 5'h1f, 1'b0, 1'b1, 1'b1);  // 21
    add_vec(1'b1, 5'h1f, 5'h00, 1'b0, 1'b1, 1'b1);  // 22
    add_vec(1'b1, 5'h00, 5'h1f, 1'b0, 1'b1, 1'b1);  // 23
    add_vec(1'b0, 5'h1f, 5'h00, 1'b0, 1'b1, 1'b1);  // 24 lock drops
    for (int c = 25; c <= 29; c++) add_vec(1'b1, 5'h00, 5'h00, 1'b1, 1'b0, 1'b1);
    add_vec(1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b1);  // 30 glitch
    for (int c = 31; c <= 39; c++) add_vec(1'b1, 5'h00, 5'h00, 1'b1, 1'b0, 1'b1);
    add_vec(1'b1, 5'h00, 5'h1f, 1'b0, 1'b1, 1'b1);  // 40 re-release
    add_vec(1'b1, 5'h1f, 5'h00, 1'b0, 1'b1, 1'b1);  // 41

    en_pat[0] = 15'b000100010001000; sq_pat[0] = 15'b110011001100110;
    en_pat[1] = 15'b000010000100001; sq_pat[1] = 15'b110001100011000;
    en_pat[2] = 15'b111111111111111; sq_pat[2] = 15'b000000000000000;
    en_pat[3] = 15'b111111111111111; sq_pat[3] = 15'b000000000000000;
    en_pat[4] = 15'b010101010101010; sq_pat[4] = 15'b101010101010101;

    RST_N = 1'b0; LOCKED_IN = 1'b0; CFG_VALID = 1'b0; CFG_CH = '0; CFG_DIV = '0;
    repeat (3) step();
    chk_reset_vals("reset");
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      LOCKED_IN = vecs[i].lk;
      chk($sformatf("v%0d.en", i),   32'(EN_OUT),    32'(vecs[i].en));
      chk($sformatf("v%0d.sq", i),   32'(SQ_OUT),    32'(vecs[i].sq));
      chk($sformatf("v%0d.rst", i),  32'(RST_OUT),   32'(vecs[i].rst));
      chk($sformatf("v%0d.rdy", i),  32'(READY),     32'(vecs[i].rdy));
      chk($sformatf("v%0d.cfgr", i), 32'(CFG_READY), 32'(vecs[i].cfgr));
      step();
    end

    // Drop lock, program divisors while in WAIT_LOCK.
    LOCKED_IN = 1'b0;
    step();
    chk("idle.rst", 32'(RST_OUT), 32'h1);
    cfg_write(0, 4, 1'b0);
    cfg_write(1, 5, 1'b0);
    cfg_write(2, 1, 1'b0);
    cfg_write(3, 0, 1'b0);
    cfg_write(7, 9, 1'b1);
    lock_and_wait("lock2");

    // Per-channel divide and duty from RUN entry (k = 0).
    for (k = 0; k < 15; k++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        exp_en[i] = en_pat[i][14 - k];
        exp_sq[i] = sq_pat[i][14 - k];
      end
      chk($sformatf("div.en%0d", k), 32'(EN_OUT), 32'(exp_en));
      chk($sformatf("div.sq%0d", k), 32'(SQ_OUT), 32'(exp_sq));
      step();
    end

    // Rewrite ch0 from 4 to 3 at cnt=1; current period completes first.
    for (k = 15; k <= 28; k++) begin
      if (k == 17) begin
        CFG_VALID = 1'b1; CFG_CH = 3'd0; CFG_DIV = 16'd3;
      end
      chk($sformatf("upd.en%0d", k), 32'(EN_OUT[0]),
          (k == 15 || k == 19 || k == 22 || k == 25 || k == 28) ? 32'h1 : 32'h0);
      chk($sformatf("upd.sq%0d", k), 32'(SQ_OUT[0]),
          (k == 16 || k == 17 || k == 20 || k == 23 || k == 26) ? 32'h1 : 32'h0);
      chk($sformatf("upd.cfgr%0d", k), 32'(CFG_READY),
          (k == 18 || k == 19) ? 32'h0 : 32'h1);
      step();
      CFG_VALID = 1'b0;
    end

    // k = 29: ch1 at its boundary; pending write for ch1 sits until k = 34.
    CFG_VALID = 1'b1; CFG_CH = 3'd1; CFG_DIV = 16'd7;
    step();
    CFG_VALID = 1'b0;
    chk("pend.cfgr30", 32'(CFG_READY), 32'h0);
    step();
    chk("pend.cfgr31", 32'(CFG_READY), 32'h0);
    #2 RST_N = 1'b0;
    #1 chk_reset_vals("async");
    repeat (2) step();
    RST_N = 1'b1;

    // Divisors must be back to the default 2 on every channel.
    lock_and_wait("lock3");
    chk("post.en0", 32'(EN_OUT), 32'h00);
    chk("post.sq0", 32'(SQ_OUT), 32'h1f);
    step();
    chk("post.en1", 32'(EN_OUT), 32'h1f);
    chk("post.sq1", 32'(SQ_OUT), 32'h00);
    step();
    chk("post.en2", 32'(EN_OUT), 32'h00);
    chk("post.sq2", 32'(SQ_OUT), 32'h1f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
